// File: rtl/mips32_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips32_pkg
// Brief   : Shared loader state type, error codes and core opcode constants.
// Revision: 1.0 - initial release
// ============================================================================
package mips32_pkg;

  typedef enum logic [2:0] {
    ST_CNT_HI = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_START  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } load_state_t;

  localparam logic [1:0] c_err_none     = 2'd0;
  localparam logic [1:0] c_err_zero_cnt = 2'd1;
  localparam logic [1:0] c_err_capacity = 2'd2;
  localparam logic [1:0] c_err_checksum = 2'd3;

  localparam logic [5:0]  c_op_hlt    = 6'h3f;
  localparam logic [31:0] c_hlt_instr = {c_op_hlt, 26'd0};

endpackage
`default_nettype wire

// File: rtl/mips32_word_assembler.sv
`default_nettype none
// ============================================================================
// Module  : mips32_word_assembler
// Brief   : Packs MSB-first bytes into 32-bit words and keeps a running XOR.
// Revision: 1.0 - initial release
// ============================================================================
module mips32_word_assembler (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  csum
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;
  logic [7:0]  r_csum;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else if (clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_csum  <= '0;
    end else if (byte_en) begin
      r_shift <= {r_shift[15:0], byte_data};
      r_cnt   <= r_cnt + 2'd1;
      r_csum  <= r_csum ^ byte_data;
    end
  end

  // The 4th byte completes the word in the same cycle; the top registers it.
  assign word       = {r_shift, byte_data};
  assign word_valid = byte_en && (r_cnt == 2'd3);
  assign csum       = r_csum;

endmodule
`default_nettype wire

// File: rtl/mips32_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : mips32_prog_loader
// Brief   : Framed byte-stream program loader; fills instruction memory and
//           releases the MIPS32 core once the image checksum verifies.
// Revision: 1.0 - initial release
// ============================================================================
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_start,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  localparam logic [16:0] c_capacity = 17'(1) << ADDR_W;

  load_state_t       r_state;
  logic [7:0]        r_cnt_hi;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_last;

  logic              w_accept;
  logic              w_byte_en;
  logic              w_clr;
  logic [15:0]       w_count;
  logic [31:0]       w_word;
  logic              w_word_valid;
  logic [7:0]        w_csum;

  assign w_accept  = in_valid && in_ready;
  assign w_byte_en = w_accept && (r_state == ST_DATA);
  assign w_clr     = w_accept && (r_state == ST_CNT_LO);
  assign w_count   = {r_cnt_hi, in_data};

  mips32_word_assembler u_asm (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clr        (w_clr),
    .byte_en    (w_byte_en),
    .byte_data  (in_data),
    .word       (w_word),
    .word_valid (w_word_valid),
    .csum       (w_csum)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CNT_HI;
      r_cnt_hi   <= '0;
      r_wptr     <= '0;
      r_last     <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_hold  <= 1'b1;
      core_start <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      err_code   <= c_err_none;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        ST_CNT_HI: begin
          in_ready <= 1'b1;
          if (w_accept) begin
            r_cnt_hi <= in_data;
            r_state  <= ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (w_accept) begin
            if (w_count == 16'd0) begin
              r_state  <= ST_ERR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
              err_code <= c_err_zero_cnt;
            end else if ({1'b0, w_count} > c_capacity) begin
              r_state  <= ST_ERR;
              in_ready <= 1'b0;
              load_err <= 1'b1;
              err_code <= c_err_capacity;
            end else begin
              r_state <= ST_DATA;
              r_wptr  <= '0;
              r_last  <= ADDR_W'(w_count - 16'd1);
            end
          end
        end
        ST_DATA: begin
          if (w_word_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_wptr;
            mem_wdata <= w_word;
            r_wptr    <= r_wptr + ADDR_W'(1);
            if (r_wptr == r_last) begin
              r_state <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_accept) begin
            in_ready <= 1'b0;
            if (in_data == w_csum) begin
              r_state    <= ST_START;
              core_start <= 1'b1;
              core_hold  <= 1'b0;
            end else begin
              // Already-written words stay in memory; the core simply stays held.
              r_state  <= ST_ERR;
              load_err <= 1'b1;
              err_code <= c_err_checksum;
            end
          end
        end
        ST_START: begin
          core_start <= 1'b0;
          load_done  <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE, ST_ERR: begin
          if (rearm) begin
            r_state   <= ST_CNT_HI;
            in_ready  <= 1'b1;
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= c_err_none;
          end
        end
        default: begin
          r_state <= ST_CNT_HI;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips32_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips32_prog_loader
// Brief   : Scoreboard bench for the MIPS32 program loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips32_prog_loader;
  import mips32_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              rearm = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              core_start;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;

  int checks = 0;
  int passed = 0;
  int start_cnt = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] mon_e;
  logic [31:0]        img[$];

  always #5 clk1 = ~clk1;

  mips32_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rearm      (rearm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .core_start (core_start),
    .load_done  (load_done),
    .load_err   (load_err),
    .err_code   (err_code)
  );

  // Write scoreboard and start-pulse counter.
  always @(negedge clk1) begin
    if (rst_n) begin
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL write_unexpected: got addr %0d data %h, required no write", mem_addr, mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({mem_addr, mem_wdata} !== mon_e)
            $display("FAIL write_data: got addr %0d data %h, required addr %0d data %h",
                     mem_addr, mem_wdata, mon_e[ADDR_W+31:32], mon_e[31:0]);
          else passed++;
        end
      end
      if (core_start) start_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    int t;
    logic acc;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin @(posedge clk1); #1; end
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 20) begin
      @(negedge clk1);
      acc = in_ready;
      @(posedge clk1); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL byte_accept_timeout: in_ready stayed 0, required 1 within 20 cycles");
    end
  endtask

  task automatic send_count(input logic [15:0] n, input int gapmax);
    send_byte(n[15:8], gapmax);
    send_byte(n[7:0], gapmax);
  endtask

  task automatic send_body(input int gapmax, output logic [7:0] x);
    x = 8'h00;
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({ADDR_W'(i), img[i]});
      for (int k = 3; k >= 0; k--) begin
        send_byte(img[i][8*k +: 8], gapmax);
        x ^= img[i][8*k +: 8];
      end
    end
  endtask

  task automatic do_rearm;
    rearm = 1'b1;
    @(posedge clk1); #1;
    rearm = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    rearm = 1'b0;
    repeat (2) begin @(posedge clk1); #1; end
    rst_n = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    checks++;
    if ({in_ready, mem_we, core_hold, core_start, load_done, load_err} !== 6'b001000)
      $display("FAIL reset_ctrl: got rdy/we/hold/start/done/err %b, required 001000",
               {in_ready, mem_we, core_hold, core_start, load_done, load_err});
    else passed++;
    checks++;
    if ({mem_addr, mem_wdata, err_code} !== '0)
      $display("FAIL reset_data: got addr %0d data %h code %0d, required 0 0 0", mem_addr, mem_wdata, err_code);
    else passed++;
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(posedge clk1);
    @(negedge clk1);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    else passed++;
    @(posedge clk1); #1;
  endtask

  task automatic test_single_hlt;
    logic [7:0] x;
    int s0;
    img = '{c_hlt_instr};
    send_count(16'h0001, 0);
    send_body(0, x);
    s0 = start_cnt;
    send_byte(8'hfc, 0);
    @(negedge clk1);
    checks++;
    if ({core_start, core_hold, load_done} !== 3'b100)
      $display("FAIL hlt_start: got start/hold/done %b, required 100", {core_start, core_hold, load_done});
    else passed++;
    @(posedge clk1); #1;
    @(negedge clk1);
    checks++;
    if ({core_start, core_hold, load_done, load_err} !== 4'b0010)
      $display("FAIL hlt_done: got start/hold/done/err %b, required 0010", {core_start, core_hold, load_done, load_err});
    else passed++;
    @(posedge clk1); #1;
    checks++;
    if (start_cnt !== s0 + 1 || exp_q.size() != 0)
      $display("FAIL hlt_pulse: got starts %0d pending writes %0d, required 1 and 0", start_cnt - s0, exp_q.size());
    else passed++;
  endtask

  task automatic test_bad_checksum;
    logic [7:0] x;
    int s0;
    do_rearm();
    img = '{32'h2801000a};
    send_count(16'h0001, 0);
    send_body(0, x);
    s0 = start_cnt;
    send_byte(8'h24, 0);
    @(negedge clk1);
    checks++;
    if ({load_err, err_code, core_hold, core_start, in_ready} !== {1'b1, c_err_checksum, 3'b100})
      $display("FAIL csum_err: got err/code/hold/start/rdy %b, required %b",
               {load_err, err_code, core_hold, core_start, in_ready}, {1'b1, c_err_checksum, 3'b100});
    else passed++;
    @(posedge clk1); #1;
    checks++;
    if (start_cnt !== s0 || exp_q.size() != 0)
      $display("FAIL csum_side: got starts %0d pending writes %0d, required 0 and 0", start_cnt - s0, exp_q.size());
    else passed++;
  endtask

  task automatic test_count_errors;
    do_rearm();
    send_count(16'h0000, 0);
    @(negedge clk1);
    checks++;
    if ({load_err, err_code, in_ready} !== {1'b1, c_err_zero_cnt, 1'b0})
      $display("FAIL zero_count: got err/code/rdy %b, required %b", {load_err, err_code, in_ready}, {1'b1, c_err_zero_cnt, 1'b0});
    else passed++;
    @(posedge clk1); #1;
    do_rearm();
    send_count(16'h0401, 0);
    @(negedge clk1);
    checks++;
    if ({load_err, err_code, core_hold} !== {1'b1, c_err_capacity, 1'b1})
      $display("FAIL over_capacity: got err/code/hold %b, required %b", {load_err, err_code, core_hold}, {1'b1, c_err_capacity, 1'b1});
    else passed++;
    @(posedge clk1); #1;
    do_rearm();
    send_count(16'h0400, 0);
    @(negedge clk1);
    checks++;
    if ({load_err, err_code, in_ready} !== 4'b0001)
      $display("FAIL full_capacity: got err/code/rdy %b, required 0001", {load_err, err_code, in_ready});
    else passed++;
    @(posedge clk1); #1;
    apply_reset();
  endtask

  task automatic test_program_gaps;
    logic [7:0] x;
    int s0;
    do_rearm();
    img = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
            32'h00222000, 32'h0ce77800, 32'h00832800, c_hlt_instr};
    send_count(16'h0009, 2);
    send_body(3, x);
    s0 = start_cnt;
    send_byte(x, 2);
    @(negedge clk1);
    checks++;
    if (core_start !== 1'b1) $display("FAIL prog_start: got %b, required 1", core_start);
    else passed++;
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    checks++;
    if (start_cnt !== s0 + 1 || exp_q.size() != 0 || load_done !== 1'b1)
      $display("FAIL prog_done: got starts %0d pending %0d done %b, required 1 0 1", start_cnt - s0, exp_q.size(), load_done);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    logic [7:0] x;
    do_rearm();
    send_count(16'h0009, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({ADDR_W'(i), img[i]});
      for (int k = 3; k >= 0; k--) send_byte(img[i][8*k +: 8], 0);
    end
    send_byte(img[3][31:24], 0);
    send_byte(img[3][23:16], 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, core_hold, core_start, load_done, load_err, err_code} !== 8'b00100000)
      $display("FAIL midframe_reset: got %b, required 00100000",
               {in_ready, mem_we, core_hold, core_start, load_done, load_err, err_code});
    else passed++;
    repeat (2) begin @(posedge clk1); #1; end
    rst_n = 1'b1;
    @(posedge clk1); #1;
    checks++;
    if (exp_q.size() != 0) $display("FAIL midframe_prior_writes: got %0d pending, required 0", exp_q.size());
    else passed++;
    img = '{32'h00222000};
    send_count(16'h0001, 0);
    send_body(0, x);
    send_byte(x, 0);
    repeat (2) begin @(posedge clk1); #1; end
    checks++;
    if ({load_done, load_err, core_hold} !== 3'b100 || exp_q.size() != 0)
      $display("FAIL midframe_reload: got done/err/hold %b pending %0d, required 100 and 0",
               {load_done, load_err, core_hold}, exp_q.size());
    else passed++;
  endtask

  task automatic test_done_ignore;
    logic [7:0] x;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk1);
      checks++;
      if (in_ready !== 1'b0) $display("FAIL done_ready: got %b, required 0", in_ready);
      else passed++;
      @(posedge clk1); #1;
    end
    in_valid = 1'b0;
    do_rearm();
    @(negedge clk1);
    checks++;
    if ({core_hold, load_done, in_ready} !== 3'b101)
      $display("FAIL rearm_state: got hold/done/rdy %b, required 101", {core_hold, load_done, in_ready});
    else passed++;
    @(posedge clk1); #1;
    img = '{32'h28010005, c_hlt_instr};
    send_count(16'h0002, 1);
    send_body(1, x);
    send_byte(x, 1);
    repeat (2) begin @(posedge clk1); #1; end
    checks++;
    if ({load_done, core_hold} !== 2'b10 || exp_q.size() != 0)
      $display("FAIL second_image: got done/hold %b pending %0d, required 10 and 0", {load_done, core_hold}, exp_q.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_hlt();
    test_bad_checksum();
    test_count_errors();
    test_program_gaps();
    test_reset_midframe();
    test_done_ignore();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Byte-stream program loader upstream of the pipelined MIPS32 core. Receives a framed program image over a valid/ready byte interface, assembles big-endian 32-bit words, and writes them into the core's instruction memory from address 0 upward. Holds the core halted until the image is fully received and its checksum verifies, then issues a one-cycle start pulse that clears the core's PC, HALTED and TAKEN_BRANCH state.

## Interface
- ADDR_W, 10: instruction-memory word-address width; capacity 2**ADDR_W words.

- clk1  in  1  clock; loader runs in the core's stage-1 phase domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  byte available
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts in_data this cycle
- rearm  in  1  one-cycle pulse: leave DONE/ERR, re-hold core, await new image
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  instruction word
- core_hold  out  1  keeps core HALTED while high
- core_start  out  1  one-cycle pulse: core sets PC=0, HALTED=0, TAKEN_BRANCH=0
- load_done  out  1  image loaded and started (level)
- load_err  out  1  load failed (level)
- err_code  out  2  0 none, 1 zero count, 2 count exceeds capacity, 3 checksum mismatch

## Operation
- Frame: CNT_HI byte, CNT_LO byte (16-bit word count N, big-endian), N×4 data bytes (each word MSB first), one checksum byte = XOR of all 4N data bytes.
- A byte is accepted on a rising clk1 edge with in_valid && in_ready.
- States: CNT_HI (idle) → CNT_LO → DATA → CHECK → START → DONE; any check failure → ERR.
- CNT_LO accept: N==0 → ERR code 1; N > 2**ADDR_W → ERR code 2; else DATA, word pointer and checksum accumulator cleared.
- DATA: shift bytes into a 32-bit assembler, XOR each into the accumulator; 4th byte of a word issues the write; after word N-1 go to CHECK.
- CHECK accept: match → START; mismatch → ERR code 3. Words already written are not erased; core_hold stays high.
- START: core_start=1 for exactly one cycle, core_hold drops in the same cycle, then DONE.
- DONE/ERR: in_ready=0, bytes ignored; rearm → CNT_HI, core_hold=1, load_done/load_err/err_code cleared. rearm in any other state ignored.
- Word addresses 0..N-1 only; no wrap-around (prevented by the capacity check).

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, core_hold 1, core_start 0, load_done 0, load_err 0, err_code 0, state CNT_HI. First cycle after reset release: in_ready 1.
- in_ready = 1 in CNT_HI, CNT_LO, DATA, CHECK; throughput one byte per cycle; in_valid gaps stall without state loss.
- mem_we/mem_addr/mem_wdata registered: valid the cycle after the 4th byte of a word is accepted, mem_we high exactly one cycle.
- Last write precedes core_start by ≥1 cycle; core_start occurs the cycle after checksum accept; load_done rises the cycle after core_start.
- ERR entry and err_code valid the cycle after the offending byte accept.
- rst_n low mid-frame: immediate return to reset values; partial word discarded, no write issued.

## Structure
- Shared package mips32_pkg: state enum, err_code constants, HLT opcode constant for benches.
- One natural sub-module: mips32_word_assembler (byte shift, 4-count, word-valid pulse, XOR accumulator). FSM and address counter in top.

## Test plan
- N=0x0001, word 0xfc000000, checksum 0xfc → one write addr 0 data 0xfc000000; core_start pulse; load_done=1, core_hold=0.
- N=0x0001, word 0x2801000a, checksum 0x24 (correct 0x23) → write addr 0, then load_err=1, err_code=3, no core_start, core_hold=1.
- N=0x0000 → ERR code 1 one cycle after CNT_LO, no writes; N=0x0401 with ADDR_W=10 → ERR code 2.
- Nine-word add program (0x2801000a…0xfc000000) with random in_valid gaps → writes addr 0..8 in order, exact data, one core_start.
- rst_n asserted after 2 bytes of word 3 → all outputs at reset values, no write for word 3; fresh frame afterwards loads correctly.
- After DONE: bytes with in_valid=1 ignored (in_ready=0); rearm → core_hold=1, load_done=0, second image loads.
